// File: rtl/ex_commit_stage_if.sv
// rtl/ex_commit_stage_if.sv - execute-to-commit bundle, memory-stage handshake and exception report
interface ex_commit_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [1:0]  in_comp;
    logic [1:0]  in_sig_comp;
    logic        in_overflow;
    logic        in_op_invalid;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_wr_en;
    logic        in_trap_ovf;
    logic [2:0]  in_br_cond;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic [31:0] out_pc;
    logic        out_br_taken;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        exc_ack;

    modport slave (
        input  in_valid, in_result, in_comp, in_sig_comp, in_overflow, in_op_invalid,
               in_pc, in_rd, in_wr_en, in_trap_ovf, in_br_cond, flush, out_ready, exc_ack,
        output in_ready, out_valid, out_result, out_rd, out_wr_en, out_pc, out_br_taken,
               exc_valid, exc_cause, exc_pc
    );

    modport master (
        output in_valid, in_result, in_comp, in_sig_comp, in_overflow, in_op_invalid,
               in_pc, in_rd, in_wr_en, in_trap_ovf, in_br_cond, flush, out_ready, exc_ack,
        input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_pc, out_br_taken,
               exc_valid, exc_cause, exc_pc
    );
endinterface

// File: rtl/ex_commit_stage.sv
// rtl/ex_commit_stage.sv - 2-entry skid buffer resolving branches and latching the first exception
module ex_commit_stage #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    ex_commit_stage_if.slave bus
);
    localparam logic [1:0] ALU_EQUAL   = 2'd0;
    localparam logic [1:0] ALU_SMALLER = 2'd1;

    logic [31:0] result_q [DEPTH];
    logic [4:0]  rd_q     [DEPTH];
    logic        wr_en_q  [DEPTH];
    logic [31:0] pc_q     [DEPTH];
    logic        br_q     [DEPTH];

    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q;
    logic        exc_valid_q, exc_valid_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    logic        push, pop, br_taken, exc_hit;
    logic [1:0]  exc_code;

    always_comb begin
        br_taken = 1'b0;
        case (bus.in_br_cond)
            3'd1:    br_taken = (bus.in_comp == ALU_EQUAL);
            3'd2:    br_taken = (bus.in_comp != ALU_EQUAL);
            3'd3:    br_taken = (bus.in_sig_comp == ALU_SMALLER);
            3'd4:    br_taken = (bus.in_sig_comp != ALU_SMALLER);
            3'd5:    br_taken = (bus.in_comp == ALU_SMALLER);
            3'd6:    br_taken = (bus.in_comp != ALU_SMALLER);
            default: br_taken = 1'b0;
        endcase
    end

    // Cause priority: invalid op, reserved branch condition, trapping overflow.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = 2'd0;
        if (bus.in_op_invalid)                          exc_code = 2'd2;
        else if (bus.in_br_cond == 3'd7)                exc_code = 2'd3;
        else if (bus.in_overflow && bus.in_trap_ovf)    exc_code = 2'd1;
        else                                            exc_hit  = 1'b0;
    end

    always_comb begin
        push = bus.in_valid && in_ready_q && !bus.flush;
        pop  = (count_q != 2'd0) && bus.out_ready && !bus.flush;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (bus.flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        // An ack frees the latch in the same cycle, so a coincident new exception is kept.
        exc_valid_d = exc_valid_q && !bus.exc_ack;
        exc_cause_d = exc_cause_q;
        exc_pc_d    = exc_pc_q;
        if (push && exc_hit && !exc_valid_d) begin
            exc_valid_d = 1'b1;
            exc_cause_d = exc_code;
            exc_pc_d    = bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                result_q[i] <= '0;
                rd_q[i]     <= '0;
                wr_en_q[i]  <= 1'b0;
                pc_q[i]     <= '0;
                br_q[i]     <= 1'b0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_pc_q    <= '0;
        end else begin
            if (push) begin
                result_q[wr_ptr_q] <= bus.in_result;
                rd_q[wr_ptr_q]     <= bus.in_rd;
                wr_en_q[wr_ptr_q]  <= bus.in_wr_en && !exc_hit;
                pc_q[wr_ptr_q]     <= bus.in_pc;
                br_q[wr_ptr_q]     <= br_taken && !exc_hit;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = (count_q != 2'd0);
    assign bus.out_result   = result_q[rd_ptr_q];
    assign bus.out_rd       = rd_q[rd_ptr_q];
    assign bus.out_wr_en    = wr_en_q[rd_ptr_q];
    assign bus.out_pc       = pc_q[rd_ptr_q];
    assign bus.out_br_taken = br_q[rd_ptr_q];
    assign bus.exc_valid    = exc_valid_q;
    assign bus.exc_cause    = exc_cause_q;
    assign bus.exc_pc       = exc_pc_q;
endmodule

// File: tb/tb_ex_commit_stage.sv
// tb/tb_ex_commit_stage.sv - directed checks of ex_commit_stage buffering, branches, exceptions, flush, reset
module tb_ex_commit_stage;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ex_commit_stage_if bus ();
    ex_commit_stage #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] res,
                          input logic wr, input logic [1:0] comp, input logic [1:0] scomp,
                          input logic [2:0] br, input logic ovf, input logic trap, input logic inv);
        bus.in_valid      = v;
        bus.in_pc         = pc;
        bus.in_result     = res;
        bus.in_rd         = 5'd3;
        bus.in_wr_en      = wr;
        bus.in_comp       = comp;
        bus.in_sig_comp   = scomp;
        bus.in_br_cond    = br;
        bus.in_overflow   = ovf;
        bus.in_trap_ovf   = trap;
        bus.in_op_invalid = inv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b0; bus.out_ready = 1'b0; bus.exc_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_exc_valid", 32'(bus.exc_valid), 32'd0);

        // single bundle, one-cycle latency
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'h100, 32'h5, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("lat_valid",  32'(bus.out_valid), 32'd1);
        chk("lat_result", bus.out_result, 32'h5);
        chk("lat_pc",     bus.out_pc, 32'h100);
        chk("lat_rd",     32'(bus.out_rd), 32'd3);
        chk("lat_wr_en",  32'(bus.out_wr_en), 32'd1);
        tick();
        chk("lat_drain",  32'(bus.out_valid), 32'd0);

        // backpressure: two accepts, third held off until space frees
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h100, 32'hA, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        bus.in_pc = 32'h104;
        tick();
        chk("bp_ready2", 32'(bus.in_ready), 32'd0);
        bus.in_pc = 32'h108;
        tick();
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_stable_pc",  bus.out_pc, 32'h100);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second_pc", bus.out_pc, 32'h104);
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_third_pc", bus.out_pc, 32'h108);
        chk("bp_third_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // branch resolution (comp codes: 0 equal, 1 smaller, 2 larger)
        set_in(1'b1, 32'h110, 32'h0, 1'b0, 2'd2, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_lt_taken", 32'(bus.out_br_taken), 32'd1);
        set_in(1'b1, 32'h114, 32'h0, 1'b0, 2'd2, 2'd1, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_ltu_not", 32'(bus.out_br_taken), 32'd0);
        set_in(1'b1, 32'h118, 32'h0, 1'b0, 2'd2, 2'd1, 3'd6, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_geu_taken", 32'(bus.out_br_taken), 32'd1);
        set_in(1'b1, 32'h11C, 32'h0, 1'b0, 2'd1, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_ne_taken", 32'(bus.out_br_taken), 32'd1);
        bus.in_valid = 1'b0;
        tick();

        // exceptions: first one held, bundles still flow with wr_en killed
        set_in(1'b1, 32'h200, 32'h7, 1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ovf_wr_en",  32'(bus.out_wr_en), 32'd0);
        chk("ovf_exc_v",  32'(bus.exc_valid), 32'd1);
        chk("ovf_cause",  32'(bus.exc_cause), 32'd1);
        chk("ovf_pc",     bus.exc_pc, 32'h200);
        set_in(1'b1, 32'h204, 32'h8, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("inv_out_pc", bus.out_pc, 32'h204);
        chk("inv_wr_en",  32'(bus.out_wr_en), 32'd0);
        chk("held_cause", 32'(bus.exc_cause), 32'd1);
        chk("held_pc",    bus.exc_pc, 32'h200);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        chk("ack_clear", 32'(bus.exc_valid), 32'd0);
        set_in(1'b1, 32'h300, 32'h0, 1'b1, 2'd0, 2'd0, 3'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rsv_cause", 32'(bus.exc_cause), 32'd3);
        chk("rsv_br",    32'(bus.out_br_taken), 32'd0);
        set_in(1'b1, 32'h304, 32'h0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        bus.exc_ack = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ackcoin_valid", 32'(bus.exc_valid), 32'd1);
        chk("ackcoin_cause", 32'(bus.exc_cause), 32'd2);
        chk("ackcoin_pc",    bus.exc_pc, 32'h304);
        tick();
        bus.exc_ack = 1'b0;
        chk("ack2_clear", 32'(bus.exc_valid), 32'd0);

        // flush with two entries buffered and a bundle offered
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h400, 32'h1, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_pc = 32'h404;
        tick();
        bus.in_pc = 32'h408;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2_valid", 32'(bus.out_valid), 32'd0);
        chk("fl2_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("fl2_none", 32'(bus.out_valid), 32'd0);
        // flush with one entry and an acceptable push: the push is dropped too
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h500, 32'h1, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_pc = 32'h504;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("fl1_none", 32'(bus.out_valid), 32'd0);

        // reset with a pending exception and one buffered entry
        set_in(1'b1, 32'h600, 32'h9, 1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_exc", 32'(bus.exc_valid), 32'd1);
        chk("pre_rst_out", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        bus.flush = 1'b1;
        tick();
        reset = 1'b0;
        bus.flush = 1'b0;
        chk("rst2_exc_valid", 32'(bus.exc_valid), 32'd0);
        chk("rst2_exc_cause", 32'(bus.exc_cause), 32'd0);
        chk("rst2_exc_pc",    bus.exc_pc, 32'd0);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst2_result",    bus.out_result, 32'd0);
        chk("rst2_pc",        bus.out_pc, 32'd0);
        chk("rst2_rd",        32'(bus.out_rd), 32'd0);
        chk("rst2_wr_en",     32'(bus.out_wr_en), 32'd0);
        chk("rst2_br",        32'(bus.out_br_taken), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_commit_stage.md
EX_COMMIT_STAGE -- requirements
Module: ex_commit_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the buffer entry count; only the value 2 is legal.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  the execute-stage bundle is valid.
REQ-005 SHALL have port in_ready  output  1  the stage can accept the bundle this cycle.
REQ-006 SHALL have port in_result  input  32  the ALU result.
REQ-007 SHALL have ports in_comp and in_sig_comp  input  2 each  the unsigned and signed compare codes ALU_EQUAL, ALU_SMALLER and ALU_LARGER from alu.h.
REQ-008 SHALL have ports in_overflow and in_op_invalid  input  1 each  the ALU status flags.
REQ-009 SHALL have ports in_pc  input  32, in_rd  input  5, in_wr_en  input  1, in_trap_ovf  input  1  the instruction context.
REQ-010 SHALL have port in_br_cond  input  3  the branch condition: 0 none, 1 eq, 2 ne, 3 lt signed, 4 ge signed, 5 ltu, 6 geu, 7 reserved.
REQ-011 SHALL have port flush  input  1  kills every buffered and incoming bundle.
REQ-012 SHALL have ports out_valid  output  1 and out_ready  input  1  the downstream (memory stage) handshake.
REQ-013 SHALL have ports out_result  output  32, out_rd  output  5, out_wr_en  output  1, out_pc  output  32, out_br_taken  output  1.
REQ-014 SHALL have ports exc_valid  output  1, exc_cause  output  2 (1 overflow, 2 invalid op, 3 reserved branch condition), exc_pc  output  32, exc_ack  input  1.

Function
REQ-015 SHALL be a 2-entry FIFO skid buffer: a transfer occurs on in_valid&in_ready; out_valid&out_ready pops the head.
REQ-016 SHALL make in_ready a registered signal, 1 exactly when fewer than 2 entries are occupied; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL present an accepted bundle on the out_* ports with 1-cycle latency when the buffer was empty.
REQ-018 SHALL accept a push and a pop in the same cycle when 1 entry is occupied, leaving the count unchanged.
REQ-019 SHALL keep the out_* ports stable while out_valid=1 and out_ready=0.
REQ-020 SHALL set out_br_taken at push time from in_br_cond: eq if in_comp==ALU_EQUAL; ne otherwise; lt if in_sig_comp==ALU_SMALLER; ge otherwise; ltu and geu likewise from in_comp; none and 7 give 0.
REQ-021 SHALL detect an exception at push with priority in_op_invalid (cause 2), then in_br_cond==7 (cause 3), then in_overflow&in_trap_ovf (cause 1).
REQ-022 SHALL force the stored wr_en and br_taken of an excepting bundle to 0; the bundle still flows downstream.
REQ-023 SHALL latch exc_valid, exc_cause and exc_pc (= in_pc) for the first exception only; later exceptions SHALL NOT overwrite them while exc_valid=1.
REQ-024 SHALL clear exc_valid on exc_ack; if exc_ack and a new exception coincide, the new exception SHALL be latched.
REQ-025 SHALL empty the buffer on flush, ignore in_valid that cycle, and drive out_valid=0 on the next cycle; flush SHALL NOT clear the exception latch.
REQ-026 SHALL give flush priority over simultaneous push and pop.
REQ-027 SHALL wrap the read and write pointers modulo 2.

Reset
REQ-028 SHALL, on reset, empty the buffer: out_valid=0 and in_ready=1 on the following cycle.
REQ-029 SHALL, on reset, drive out_result=0, out_rd=0, out_wr_en=0, out_pc=0 and out_br_taken=0.
REQ-030 SHALL, on reset, clear exc_valid=0, exc_cause=0 and exc_pc=0.
REQ-031 SHALL drop an in-flight bundle when reset is asserted mid-transfer; reset SHALL have priority over flush and exc_ack.

Verification
REQ-032 SHALL cover: push result=0x0000_0005, pc=0x100, out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_pc=0x100.
REQ-033 SHALL cover: out_ready=0 with 3 pushes offered -> in_ready falls after 2 accepts; releasing out_ready gives in-order output pc 0x100, 0x104, then the third bundle accepted.
REQ-034 SHALL cover: br_cond=3 with in_sig_comp=ALU_SMALLER -> out_br_taken=1; br_cond=5 with in_comp=ALU_LARGER -> out_br_taken=0.
REQ-035 SHALL cover: overflow=1, trap_ovf=1, wr_en=1, pc=0x200, then op_invalid at pc=0x204 -> out_wr_en=0 on both; exc_cause=1 and exc_pc=0x200 held until exc_ack.
REQ-036 SHALL cover: 2 entries buffered plus flush with a simultaneous push -> next cycle out_valid=0, in_ready=1, and the pushed bundle is never output.
REQ-037 SHALL cover: reset while exc_valid=1 and 1 entry is buffered -> next cycle exc_valid=0, out_valid=0, all outputs 0.
